// File: rtl/broadcast_filter_requester.sv
// broadcast_filter_requester
//
// Takes one allocation at a time from an MSHR, asks the snoop filter which
// clients may hold the line, probes every client that is not the requester,
// waits for all probe acks, then reports completion for that MSHR.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. valid/ready outputs depend only on registered state, and
// payload outputs stay stable while their valid is high and not yet accepted.
//
// Ports
//   clock, reset              single clock, synchronous active-high reset
//   io_alloc_*                allocation request (mshr, address, requester OH, needT)
//   io_request_*              lookup request to the filter (latched alloc fields)
//   io_response_*             filter answer (allocOH = clients that do NOT need a probe)
//   io_probe_*                one probe per client: index, address, toN
//   io_probeack_valid         probe ack, always accepted, at most one per cycle
//   io_done_*                 completion for the latched mshr
//   io_error                  sticky: filter echo mismatch or unexpected ack
//   dbg_state                 current FSM state, for observation only
module broadcast_filter_requester #(
  parameter  int CLIENTS  = 2,
  parameter  int MAX_PEND = 3,
  localparam int CW       = (CLIENTS > 1) ? $clog2(CLIENTS) : 1,
  localparam int PW       = $clog2(MAX_PEND + 1)
) (
  input  logic               clock,
  input  logic               reset,

  output logic               io_alloc_ready,
  input  logic               io_alloc_valid,
  input  logic [1:0]         io_alloc_bits_mshr,
  input  logic [25:0]        io_alloc_bits_address,
  input  logic [CLIENTS-1:0] io_alloc_bits_allocOH,
  input  logic               io_alloc_bits_needT,

  output logic               io_request_valid,
  input  logic               io_request_ready,
  output logic [1:0]         io_request_bits_mshr,
  output logic [25:0]        io_request_bits_address,
  output logic [CLIENTS-1:0] io_request_bits_allocOH,
  output logic               io_request_bits_needT,

  output logic               io_response_ready,
  input  logic               io_response_valid,
  input  logic [1:0]         io_response_bits_mshr,
  input  logic [25:0]        io_response_bits_address,
  input  logic [CLIENTS-1:0] io_response_bits_allocOH,
  input  logic               io_response_bits_needT,

  output logic               io_probe_valid,
  input  logic               io_probe_ready,
  output logic [CW-1:0]      io_probe_bits_client,
  output logic [25:0]        io_probe_bits_address,
  output logic               io_probe_bits_toN,

  input  logic               io_probeack_valid,

  output logic               io_done_valid,
  input  logic               io_done_ready,
  output logic [1:0]         io_done_bits_mshr,
  output logic               io_error,

  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_RESP  = 3'd2,
    S_PROBE = 3'd3,
    S_ACK   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PEND);

  state_t             state_q, state_d;
  logic [1:0]         mshr_q;
  logic [25:0]        addr_q;
  logic [CLIENTS-1:0] alloc_oh_q;
  logic               need_t_q;
  logic [CLIENTS-1:0] mask_q;
  logic [PW-1:0]      pend_q, pend_d;
  logic               error_q;

  logic               alloc_fire, request_fire, response_fire, probe_fire, done_fire;
  logic               stray_ack, echo_mismatch;
  logic [CW-1:0]      probe_idx;
  logic [CLIENTS-1:0] probe_bit, mask_left, resp_mask;

  // Handshake outputs are pure functions of the registered state, so exactly
  // one (or none, in ACK / throttled PROBE) is high at a time.
  assign io_alloc_ready    = (state_q == S_IDLE);
  assign io_request_valid  = (state_q == S_REQ);
  assign io_response_ready = (state_q == S_RESP);
  assign io_probe_valid    = (state_q == S_PROBE) && (pend_q != PEND_MAX);
  assign io_done_valid     = (state_q == S_DONE);

  assign alloc_fire    = io_alloc_valid    && io_alloc_ready;
  assign request_fire  = io_request_valid  && io_request_ready;
  assign response_fire = io_response_valid && io_response_ready;
  assign probe_fire    = io_probe_valid    && io_probe_ready;
  assign done_fire     = io_done_valid     && io_done_ready;

  assign io_request_bits_mshr    = mshr_q;
  assign io_request_bits_address = addr_q;
  assign io_request_bits_allocOH = alloc_oh_q;
  assign io_request_bits_needT   = need_t_q;
  assign io_probe_bits_client    = probe_idx;
  assign io_probe_bits_address   = addr_q;
  assign io_probe_bits_toN       = need_t_q;
  assign io_done_bits_mshr       = mshr_q;
  assign io_error                = error_q;
  assign dbg_state               = state_q;

  assign resp_mask     = ~io_response_bits_allocOH;
  assign mask_left     = mask_q & ~probe_bit;
  assign echo_mismatch = (io_response_bits_mshr != mshr_q) ||
                         (io_response_bits_address != addr_q);

  // Lowest set mask bit: scanning downwards lets the lowest index win.
  always_comb begin
    probe_idx = '0;
    probe_bit = '0;
    for (int i = CLIENTS - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        probe_idx    = CW'(i);
        probe_bit    = '0;
        probe_bit[i] = 1'b1;
      end
    end
  end

  // Outstanding probe count. A fire and an ack in the same cycle cancel.
  // An ack with nothing outstanding (and no probe leaving now) is flagged
  // and dropped so the count never wraps.
  always_comb begin
    pend_d    = pend_q;
    stray_ack = 1'b0;
    if (probe_fire && !io_probeack_valid) begin
      pend_d = pend_q + 1'b1;
    end else if (!probe_fire && io_probeack_valid) begin
      if (pend_q == '0) stray_ack = 1'b1;
      else              pend_d    = pend_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (alloc_fire)   state_d = S_REQ;
      S_REQ:   if (request_fire) state_d = S_RESP;
      S_RESP:  if (response_fire) state_d = (|resp_mask) ? S_PROBE : S_DONE;
      S_PROBE: begin
        // Skip ACK when the last probe leaves with nothing left outstanding.
        if (probe_fire && (mask_left == '0))
          state_d = (pend_d == '0) ? S_DONE : S_ACK;
      end
      S_ACK:   if (pend_d == '0) state_d = S_DONE;
      S_DONE:  if (done_fire)    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      mshr_q     <= '0;
      addr_q     <= '0;
      alloc_oh_q <= '0;
      need_t_q   <= 1'b0;
      mask_q     <= '0;
      pend_q     <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if (stray_ack) error_q <= 1'b1;
      if (alloc_fire) begin
        mshr_q     <= io_alloc_bits_mshr;
        addr_q     <= io_alloc_bits_address;
        alloc_oh_q <= io_alloc_bits_allocOH;
        need_t_q   <= io_alloc_bits_needT;
      end
      if (response_fire) begin
        mask_q   <= resp_mask;
        need_t_q <= io_response_bits_needT;
        if (echo_mismatch) error_q <= 1'b1;
      end else if (probe_fire) begin
        mask_q <= mask_left;
      end
    end
  end

endmodule
